// File: rtl/img_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_ctrl_pkg
// Description : Shared types and constants for the image coprocessor sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package img_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DMA_WAIT = 3'd1,
        S_DMA_RUN  = 3'd2,
        S_FILTER   = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_K1  = 3'd1;
    localparam logic [2:0] OP_K2  = 3'd2;
    localparam logic [2:0] OP_K3  = 3'd3;
    localparam logic [2:0] OP_K4  = 3'd4;
    localparam logic [2:0] OP_K5  = 3'd5;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_TMO  = 2;
    localparam int ST_ILL  = 3;
    localparam int ST_OVR  = 4;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_K5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/img_coproc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : img_coproc_ctrl_if
// Description : CPU MMIO, DMA/filter handshake and buffer-ownership bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface img_coproc_ctrl_if;
    logic       cmd_we;
    logic [7:0] cmd_wdata;
    logic       status_re;
    logic [7:0] status_rdata;
    logic       dma_start;
    logic       dma_rdy;
    logic       dma_done;
    logic       flt_start;
    logic [2:0] flt_op;
    logic       flt_done;
    logic       cpu_buf_req;
    logic       cpu_buf_gnt;
    logic       buf_sel;
    logic       busy;
    logic       irq;

    // master is the sequencer side; slave is the CPU/engine side
    modport master (
        input  cmd_we, cmd_wdata, status_re, dma_rdy, dma_done, flt_done, cpu_buf_req,
        output status_rdata, dma_start, flt_start, flt_op, cpu_buf_gnt, buf_sel, busy, irq
    );

    modport slave (
        output cmd_we, cmd_wdata, status_re, dma_rdy, dma_done, flt_done, cpu_buf_req,
        input  status_rdata, dma_start, flt_start, flt_op, cpu_buf_gnt, buf_sel, busy, irq
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_wdog.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_wdog
// Description : Saturating watchdog; expired while the counter is all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_wdog #(
    parameter int TIMEOUT_W = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    logic [TIMEOUT_W-1:0] r_cnt;

    assign expired = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/img_coproc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : img_coproc_ctrl
// Description : Command sequencer: DMA load, filter run, drain, completion.
// Revision    : 1.0 - initial release
// ============================================================================
module img_coproc_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int DRAIN_CYC = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    img_coproc_ctrl_if.master  bus
);

    localparam logic [3:0] C_DRAIN_INIT = 4'(DRAIN_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic       r_irq_en;
    logic [3:0] r_drain;
    logic       r_flt_pend;
    logic       r_done, r_tmo, r_ill, r_ovr;
    logic       w_expired, w_wdog_en, w_wdog_clr;
    logic       w_idle_cmd;
    logic [2:0] w_cmd_op;
    logic [7:0] w_status;
    logic       w_unused;

    assign w_cmd_op   = bus.cmd_wdata[2:0];
    assign w_idle_cmd = (r_state == S_IDLE) && bus.cmd_we;
    assign w_unused   = &{1'b0, bus.cmd_wdata[6:3]};

    assign w_wdog_en  = (r_state inside {S_DMA_WAIT, S_DMA_RUN, S_FILTER});
    assign w_wdog_clr = (w_next != r_state);

    ctrl_wdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_wdog_clr),
        .en      (w_wdog_en),
        .expired (w_expired)
    );

    // Timeout takes priority over any engine event arriving in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_we) begin
                    if (w_cmd_op == OP_NOP)       w_next = S_DONE;
                    else if (!op_illegal(w_cmd_op)) w_next = S_DMA_WAIT;
                end
            end
            S_DMA_WAIT: begin
                if (w_expired)        w_next = S_IDLE;
                else if (bus.dma_rdy) w_next = S_DMA_RUN;
            end
            S_DMA_RUN: begin
                if (w_expired)         w_next = S_IDLE;
                else if (bus.dma_done) w_next = S_FILTER;
            end
            S_FILTER: begin
                if (w_expired)         w_next = S_IDLE;
                else if (bus.flt_done) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == 4'd0) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_irq_en   <= 1'b0;
            r_drain    <= 4'd0;
            r_flt_pend <= 1'b0;
            r_done     <= 1'b0;
            r_tmo      <= 1'b0;
            r_ill      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_flt_pend <= (r_state == S_DMA_RUN) && (w_next == S_FILTER);

            if (w_idle_cmd) begin
                r_op     <= w_cmd_op;
                r_irq_en <= bus.cmd_wdata[7];
            end

            if (r_state == S_FILTER)                       r_drain <= C_DRAIN_INIT;
            else if (r_state == S_DRAIN && r_drain != 4'd0) r_drain <= r_drain - 1'b1;

            // Sticky flags: a set in the same cycle as a read-clear wins
            r_done <= (r_state == S_DONE) | (r_done & ~bus.status_re);
            r_tmo  <= (w_expired & w_wdog_en) | (r_tmo & ~bus.status_re);
            r_ill  <= (w_idle_cmd & op_illegal(w_cmd_op)) | (r_ill & ~bus.status_re);
            r_ovr  <= (bus.cmd_we & (r_state != S_IDLE)) | (r_ovr & ~bus.status_re);
        end
    end

    always_comb begin
        w_status          = 8'h00;
        w_status[ST_BUSY] = (r_state != S_IDLE);
        w_status[ST_DONE] = r_done;
        w_status[ST_TMO]  = r_tmo;
        w_status[ST_ILL]  = r_ill;
        w_status[ST_OVR]  = r_ovr;
        w_status[7:5]     = r_op;
    end

    assign bus.status_rdata = w_status;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.buf_sel      = (r_state inside {S_DMA_WAIT, S_DMA_RUN, S_FILTER, S_DRAIN});
    assign bus.cpu_buf_gnt  = bus.cpu_buf_req & ~bus.buf_sel;
    assign bus.dma_start    = (r_state == S_DMA_WAIT) && (w_next == S_DMA_RUN);
    assign bus.flt_start    = r_flt_pend && (r_state == S_FILTER);
    assign bus.flt_op       = r_op;
    assign bus.irq          = r_irq_en & (r_done | r_tmo | r_ill);

endmodule
`default_nettype wire

// File: tb/tb_img_coproc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_coproc_ctrl
// Description : Directed scoreboard bench for the image coprocessor sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_coproc_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    img_coproc_ctrl_if bus_if ();

    img_coproc_ctrl #(
        .TIMEOUT_W (4),
        .DRAIN_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        string       name;
        logic [12:0] exp;
    } snap_t;

    snap_t      snap_q[$];
    logic [3:0] pulse_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // {status_rdata, buf_sel, irq, cpu_buf_gnt, dma_start, flt_start}
    function automatic logic [12:0] mk(input logic [7:0] st, input logic bs, input logic irq,
                                       input logic gnt, input logic ds, input logic fs);
        return {st, bs, irq, gnt, ds, fs};
    endfunction

    task automatic exp_snap(input string n, input logic [12:0] e);
        snap_t s;
        s.name = n;
        s.exp  = e;
        snap_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulse(input string n, input logic [3:0] act);
        logic [3:0] e;
        vectors++;
        if (pulse_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected pulse kind/op=%h, none expected", n, act);
        end else begin
            e = pulse_q.pop_front();
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got kind/op=%h expected %h", n, act, e);
            end
        end
    endtask

    // Monitor: compare queued snapshots and every start pulse away from the edge
    initial begin
        logic [12:0] act;
        snap_t       s;
        forever begin
            @(negedge clk);
            act = {bus_if.status_rdata, bus_if.buf_sel, bus_if.irq, bus_if.cpu_buf_gnt,
                   bus_if.dma_start, bus_if.flt_start};
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                vectors++;
                if (act !== s.exp) begin
                    miscompares++;
                    $display("FAIL %s: got {st,bs,irq,gnt,ds,fs}=%h_%b expected %h_%b",
                             s.name, act[12:5], act[4:0], s.exp[12:5], s.exp[4:0]);
                end
            end
            if (bus_if.dma_start === 1'b1) check_pulse("dma_start", {1'b0, bus_if.flt_op});
            if (bus_if.flt_start === 1'b1) check_pulse("flt_start", {1'b1, bus_if.flt_op});
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no finish, expected finish before limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n               = 1'b0;
        bus_if.cmd_we       = 1'b0;
        bus_if.cmd_wdata    = 8'h00;
        bus_if.status_re    = 1'b0;
        bus_if.dma_rdy      = 1'b0;
        bus_if.dma_done     = 1'b0;
        bus_if.flt_done     = 1'b0;
        bus_if.cpu_buf_req  = 1'b0;
        tick(); tick();
        exp_snap("reset", mk(8'h00, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        exp_snap("after_release", mk(8'h00, 0, 0, 0, 0, 0));

        // Opcode 3 with irq_en; DMA ready immediately
        tick();
        bus_if.cpu_buf_req = 1'b1;
        bus_if.dma_rdy     = 1'b1;
        bus_if.cmd_we      = 1'b1;
        bus_if.cmd_wdata   = 8'h83;
        pulse_q.push_back({1'b0, 3'd3});
        exp_snap("t1_idle_gnt", mk(8'h00, 0, 0, 1, 0, 0));
        tick();
        bus_if.cmd_we = 1'b0;
        exp_snap("t1_dma_start", mk(8'h61, 1, 0, 0, 1, 0));
        tick();
        exp_snap("t1_single_pulse", mk(8'h61, 1, 0, 0, 0, 0));
        tick();
        bus_if.dma_done = 1'b1;
        pulse_q.push_back({1'b1, 3'd3});
        exp_snap("t2_dma_run", mk(8'h61, 1, 0, 0, 0, 0));
        tick();
        bus_if.dma_done  = 1'b0;
        bus_if.cmd_we    = 1'b1;
        bus_if.cmd_wdata = 8'h05;
        exp_snap("t2_flt_start", mk(8'h61, 1, 0, 0, 0, 1));
        tick();
        bus_if.status_re = 1'b1;
        exp_snap("t5_overrun", mk(8'h71, 1, 0, 0, 0, 0));
        tick();
        bus_if.cmd_we    = 1'b0;
        bus_if.flt_done  = 1'b1;
        exp_snap("t5_set_wins", mk(8'h71, 1, 0, 0, 0, 0));
        tick();
        bus_if.status_re = 1'b0;
        bus_if.flt_done  = 1'b0;
        exp_snap("t2_drain_a", mk(8'h61, 1, 0, 0, 0, 0));
        tick();
        exp_snap("t2_drain_b", mk(8'h61, 1, 0, 0, 0, 0));
        tick();
        exp_snap("t2_done_state", mk(8'h61, 0, 0, 1, 0, 0));
        tick();
        exp_snap("t2_status_done", mk(8'h62, 0, 1, 1, 0, 0));
        bus_if.status_re = 1'b1;
        tick();
        bus_if.status_re = 1'b0;
        exp_snap("t2_status_cleared", mk(8'h60, 0, 0, 1, 0, 0));

        // Illegal opcode 7, first with irq_en then without
        bus_if.cmd_we    = 1'b1;
        bus_if.cmd_wdata = 8'h87;
        tick();
        bus_if.cmd_we = 1'b0;
        exp_snap("t3_illegal", mk(8'hE8, 0, 1, 1, 0, 0));
        tick();
        exp_snap("t3_stay_idle", mk(8'hE8, 0, 1, 1, 0, 0));
        bus_if.cmd_we    = 1'b1;
        bus_if.cmd_wdata = 8'h07;
        tick();
        bus_if.cmd_we = 1'b0;
        exp_snap("t3_irq_off", mk(8'hE8, 0, 0, 1, 0, 0));
        bus_if.status_re = 1'b1;
        tick();
        bus_if.status_re = 1'b0;
        exp_snap("t3_cleared", mk(8'hE0, 0, 0, 1, 0, 0));

        // Watchdog: opcode 1, dma_done never arrives
        bus_if.cmd_we    = 1'b1;
        bus_if.cmd_wdata = 8'h81;
        pulse_q.push_back({1'b0, 3'd1});
        tick();
        bus_if.cmd_we = 1'b0;
        exp_snap("t4_dma_start", mk(8'h21, 1, 0, 0, 1, 0));
        tick();
        exp_snap("t4_run_entry", mk(8'h21, 1, 0, 0, 0, 0));
        repeat (15) tick();
        exp_snap("t4_run_last", mk(8'h21, 1, 0, 0, 0, 0));
        tick();
        exp_snap("t4_timeout", mk(8'h24, 0, 1, 1, 0, 0));
        bus_if.status_re = 1'b1;
        tick();
        bus_if.status_re = 1'b0;
        exp_snap("t4_cleared", mk(8'h20, 0, 0, 1, 0, 0));

        // Opcode 2 with stray events, then reset during DRAIN
        bus_if.cmd_we    = 1'b1;
        bus_if.cmd_wdata = 8'h82;
        bus_if.dma_rdy   = 1'b0;
        tick();
        bus_if.cmd_we   = 1'b0;
        bus_if.dma_done = 1'b1;
        exp_snap("t6_wait_ignores_done", mk(8'h41, 1, 0, 0, 0, 0));
        tick();
        bus_if.dma_done = 1'b0;
        bus_if.flt_done = 1'b1;
        bus_if.dma_rdy  = 1'b1;
        pulse_q.push_back({1'b0, 3'd2});
        exp_snap("t6_dma_start", mk(8'h41, 1, 0, 0, 1, 0));
        tick();
        bus_if.flt_done = 1'b0;
        bus_if.dma_done = 1'b1;
        pulse_q.push_back({1'b1, 3'd2});
        exp_snap("t6_run", mk(8'h41, 1, 0, 0, 0, 0));
        tick();
        bus_if.dma_done    = 1'b0;
        bus_if.flt_done    = 1'b1;
        bus_if.cpu_buf_req = 1'b0;
        exp_snap("t6_flt_start", mk(8'h41, 1, 0, 0, 0, 1));
        tick();
        bus_if.flt_done = 1'b0;
        exp_snap("t6_drain", mk(8'h41, 1, 0, 0, 0, 0));
        tick();
        rst_n = 1'b0;
        exp_snap("t6_async_reset", mk(8'h00, 0, 0, 0, 0, 0));
        tick(); tick();
        rst_n = 1'b1;
        exp_snap("t6_released", mk(8'h00, 0, 0, 0, 0, 0));
        tick();
        exp_snap("t6_status_zero", mk(8'h00, 0, 0, 0, 0, 0));

        // NOP goes straight to DONE
        bus_if.cmd_we    = 1'b1;
        bus_if.cmd_wdata = 8'h80;
        tick();
        bus_if.cmd_we = 1'b0;
        exp_snap("nop_done_state", mk(8'h01, 0, 0, 0, 0, 0));
        tick();
        exp_snap("nop_done_flag", mk(8'h02, 0, 1, 0, 0, 0));
        tick(); tick();

        vectors++;
        if (pulse_q.size() != 0 || snap_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expectations: got %0d pulses/%0d snapshots pending, expected 0/0",
                     pulse_q.size(), snap_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
